// File: rtl/clock_enable_gen.sv
// clock_enable_gen: phase-accumulator clock-enable ticks on CLOCK50 with settle/lock tracking.
// Define CLOCK_ENABLE_GEN_TOGGLE_EN to add per-channel TOGGLE outputs (half tick rate square wave).
module clock_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          CLOCK50,
  input  logic                          RESETN,
  input  logic [NUM_CH*ACC_WIDTH-1:0]   INC,
  input  logic [NUM_CH-1:0]             CH_EN,
  output logic [NUM_CH-1:0]             TICK,
  output logic                          LOCKED
`ifdef CLOCK_ENABLE_GEN_TOGGLE_EN
  ,
  output logic [NUM_CH-1:0]             TOGGLE
`endif
);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  typedef enum logic {SETTLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_CH*ACC_WIDTH-1:0] inc_q, acc, acc_n;
  logic [NUM_CH-1:0] diff, carry;
  logic chg, run, locked_n;
  assign chg = |diff;
  assign run = state == RUN && !chg;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign diff[g] = CH_EN[g] && INC[g*ACC_WIDTH +: ACC_WIDTH] != inc_q[g*ACC_WIDTH +: ACC_WIDTH];
    // Accumulation only in undisturbed RUN; otherwise the channel collapses to phase 0.
    assign {carry[g], acc_n[g*ACC_WIDTH +: ACC_WIDTH]} = (run && CH_EN[g])
      ? {1'b0, acc[g*ACC_WIDTH +: ACC_WIDTH]} + {1'b0, INC[g*ACC_WIDTH +: ACC_WIDTH]}
      : '0;
  end
  always_comb begin
    state_n  = chg ? SETTLE : (state == SETTLE && cnt == CW'(LOCK_CYCLES - 1)) ? RUN : state;
    cnt_n    = (state == SETTLE && !chg && cnt != CW'(LOCK_CYCLES - 1)) ? cnt + 1'b1 : '0;
    locked_n = state_n == RUN;
  end
  always_ff @(posedge CLOCK50) begin
    if (!RESETN) begin
      state  <= SETTLE;
      cnt    <= '0;
      inc_q  <= '0;
      acc    <= '0;
      TICK   <= '0;
      LOCKED <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      inc_q  <= INC;
      acc    <= acc_n;
      TICK   <= carry;
      LOCKED <= locked_n;
    end
  end
`ifdef CLOCK_ENABLE_GEN_TOGGLE_EN
  always_ff @(posedge CLOCK50) begin
    if (!RESETN) TOGGLE <= '0;
    else TOGGLE <= run ? (TOGGLE & CH_EN) ^ carry : '0;
  end
`endif
endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Parametrised successor to the fixed 50 MHz to 25.175 MHz system clock block.
- Produces NUM_CH independent clock-enable tick streams from the single CLOCK50 domain, using per-channel phase accumulators. Each channel's rate is f_CLOCK50 * INC / 2^ACC_WIDTH.
- Provides a LOCKED indication after a programmable settle time. LOCKED drops and re-settles whenever an enabled channel's rate word changes.
- Downstream VGA/peripheral logic stays on CLOCK50 and qualifies its registers with TICK, so no derived clocks are needed.

Parameters:
- NUM_CH, 2, number of independent tick channels (>=1).
- ACC_WIDTH, 32, phase accumulator and increment width in bits (>=2).
- LOCK_CYCLES, 16, settle cycles before LOCKED asserts (>=1).

Ports:
- CLOCK50  input  1  50 MHz system clock; all logic rising-edge.
- RESETN  input  1  synchronous active-low reset.
- INC  input  NUM_CH*ACC_WIDTH  per-channel unsigned increment; channel c occupies bits [c*ACC_WIDTH +: ACC_WIDTH].
- CH_EN  input  NUM_CH  per-channel enable.
- TICK  output  NUM_CH  one-cycle clock-enable pulses, registered.
- LOCKED  output  1  high when rates are stable and ticks are valid, registered.

Behaviour:
- Interface (already decided): one clock, CLOCK50. Reset RESETN is synchronous and active-low. It is sampled only on the CLOCK50 rising edge, with no asynchronous path.
- Reset (RESETN=0 at an edge):
  - State goes to SETTLE.
  - Settle counter, all accumulators, TICK, LOCKED and the INC shadow register are cleared to 0.
  - This applies at any point, including mid-run.
- Settle counter width is $clog2(LOCK_CYCLES+1).
- INC shadow (inc_q): registered copy of INC, updated every non-reset edge.
  - Change detect: any channel c with CH_EN[c]=1 and INC slice != inc_q slice.
  - Changes on disabled channels are ignored.
- State SETTLE:
  - Counter increments each edge.
  - When the counter equals LOCK_CYCLES-1, the state goes to RUN and LOCKED<=1 on that edge.
  - So LOCKED first reads high in the LOCK_CYCLES-th cycle after RESETN is seen high.
  - Accumulators are held at 0 and TICK=0.
  - A change detect during SETTLE restarts the counter at 0.
- State RUN: for each channel with CH_EN[c]=1:
  - {carry, acc[c]} <= acc[c] + INC[c] (ACC_WIDTH+1-bit sum; wrap-around is natural modulo 2^ACC_WIDTH).
  - TICK[c] <= carry.
  - A tick is therefore visible the cycle after the overflowing addition.
  - The first possible tick appears 2 cycles after LOCKED rises.
- CH_EN[c]=0 (any state): acc[c] <= 0 and TICK[c] <= 0 on the next edge. The channel restarts from phase 0 when re-enabled.
- INC[c]=0 gives no ticks ever. INC[c]=2^ACC_WIDTH-1 gives 2^W-1 ticks per 2^W cycles.
- Change detect in RUN: on that edge:
  - State goes to SETTLE.
  - LOCKED<=0, all TICK<=0, all accumulators <=0, counter <=0.
- Simultaneous events:
  - Reset has priority over everything.
  - Change detect has priority over the SETTLE-to-RUN transition on the same edge; the counter restarts.
- Long-run rate is exact: over any 2^ACC_WIDTH consecutive RUN cycles, channel c produces exactly INC[c] ticks.
- Example: 25.175 MHz from 50 MHz with ACC_WIDTH=32 uses INC=2162516034.

Optional Feature:
- Macro: CLOCK_ENABLE_GEN_TOGGLE_EN.
- Defined:
  - Adds output port TOGGLE [NUM_CH], reset 0.
  - TOGGLE[c] inverts on every edge where TICK[c] is being set to 1. This gives a near-50% square wave at half the tick rate, for pin-level observation or external devices.
  - TOGGLE is cleared to 0 in SETTLE and when CH_EN[c]=0.
- Undefined: TOGGLE port and its logic are absent; all other behaviour is identical.

Test Plan (NUM_CH=2, ACC_WIDTH=4, LOCK_CYCLES=8):
1. Reset and lock: hold RESETN=0 for 3 cycles with CH_EN=2'b11, INC0=8, INC1=4, then release -> TICK=0 and LOCKED=0 during reset; LOCKED rises in the 8th cycle after release.
2. Rate check: after test 1, observe 64 cycles -> TICK0 alternates 0,1 with its first 1 two cycles after LOCKED rises (32 ticks); TICK1 is high every 4th cycle (16 ticks); never two consecutive highs on TICK1.
3. Boundary increments: INC0=0 and INC1=15, set before reset release -> over 48 RUN cycles TICK0 never asserts; TICK1 has exactly 45 ticks, with one low cycle per 16.
4. Re-program in RUN: change INC1 from 4 to 5 -> LOCKED=0 and TICK=0 on the next edge; LOCKED returns after 8 cycles; TICK1 then gives 5 ticks per 16 cycles. Changing INC1 while CH_EN[1]=0 -> LOCKED stays 1.
5. Channel disable and mid-run reset: drop CH_EN[0] for 5 cycles -> TICK0=0 and restarts from phase 0, while TICK1 is unaffected. Assert RESETN=0 for one edge mid-run -> all outputs 0 on the following cycle, followed by a full 8-cycle re-lock.
6. With CLOCK_ENABLE_GEN_TOGGLE_EN, INC0=8 -> TOGGLE0 toggles every 2 cycles (period 4), is 0 while not LOCKED, and is 0 while CH_EN[0]=0.
